// File: rtl/queen_pkg.sv
// Shared types and helpers for the N-Queens backtracking engine.
// Boards are sized for the largest supported N; smaller instances use the low rows/bits.
package queen_pkg;

    localparam int N_DEFAULT = 8;
    localparam int W_DEFAULT = 3;
    localparam int BOARD_BITS = N_DEFAULT * W_DEFAULT;
    localparam int BIT_IDX_W = $clog2(BOARD_BITS);
    localparam int ROW_IDX_W = $clog2(N_DEFAULT);
    localparam int COL_IDX_W = $clog2(W_DEFAULT);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        NEXT,
        BACKTRACK,
        EMIT,
        FINISH
    } state_t;

    typedef logic [W_DEFAULT-1:0] coord_t;
    typedef coord_t [N_DEFAULT-1:0] board_t;

    // Repack the first n rows at a stride of w bits: row r lands in [r*w +: w].
    function automatic logic [BOARD_BITS-1:0] pack_board(board_t b, int n, int w);
        logic [BOARD_BITS-1:0] v;
        v = '0;
        for (int r = 0; r < N_DEFAULT; r++) begin
            for (int i = 0; i < W_DEFAULT; i++) begin
                if (r < n && i < w)
                    v[BIT_IDX_W'(r * w + i)] = b[ROW_IDX_W'(r)][COL_IDX_W'(i)];
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/queen_solver_if.sv
// Control and solution-stream bundle between the start logic, the solver and the logger.
interface queen_solver_if #(
    parameter int N = 8,
    parameter int W = 3
);
    logic             start;
    logic             busy;
    logic             sol_valid;
    logic             sol_ready;
    logic [N*W-1:0]   sol_board;
    logic [7:0]       sol_count;
    logic             done;

    // master: the solver, which produces the solution stream
    modport master (
        input  start, sol_ready,
        output busy, sol_valid, sol_board, sol_count, done
    );

    modport slave (
        output start, sol_ready,
        input  busy, sol_valid, sol_board, sol_count, done
    );
endinterface

// File: rtl/queen_conflict.sv
// Combinational attack test between a candidate square and one placed queen.
// Row/column distances use W+1-bit signed differences so a span of 2^W-1 never aliases.
module queen_conflict
    import queen_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] r1,
    input  logic [W-1:0] c1,
    input  logic [W-1:0] r2,
    input  logic [W-1:0] c2,
    output logic         conflict
);
    logic [W:0] dr, dc;
    logic [W:0] adr, adc;

    assign dr  = {1'b0, r1} - {1'b0, r2};
    assign dc  = {1'b0, c1} - {1'b0, c2};
    assign adr = dr[W] ? (~dr + 1'b1) : dr;
    assign adc = dc[W] ? (~dc + 1'b1) : dc;

    assign conflict = (c1 == c2) || (adr == adc);
endmodule

// File: rtl/queen_solver.sv
// Sequential N-Queens enumerator: one conflict comparison per cycle, solutions
// streamed in lexicographic order over a valid/ready handshake.
module queen_solver
    import queen_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    queen_solver_if.master bus
);
    localparam logic [W-1:0] LAST = W'(N - 1);

    state_t                  state, state_d;
    logic [W-1:0]            r, c, k, r_m1;
    board_t                  cols;
    logic [7:0]              sol_count;
    logic                    busy;
    logic                    conflict;
    logic [BOARD_BITS-1:0]   packed_all;

    assign r_m1       = r - 1'b1;
    assign packed_all = pack_board(cols, N, W);

    queen_conflict #(.W(W)) u_conflict (
        .r1       (r),
        .c1       (c),
        .r2       (k),
        .c2       (cols[k][W-1:0]),
        .conflict (conflict)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:      if (bus.start) state_d = CHECK;
            CHECK: begin
                if (k == r) begin
                    if (r == LAST) state_d = EMIT;
                end else if (conflict) begin
                    state_d = NEXT;
                end
            end
            NEXT:      state_d = (c == LAST) ? BACKTRACK : CHECK;
            BACKTRACK: state_d = (r == '0) ? FINISH : NEXT;
            EMIT:      if (bus.sol_ready) state_d = NEXT;
            FINISH:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r         <= '0;
            c         <= '0;
            k         <= '0;
            cols      <= '0;
            sol_count <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        r         <= '0;
                        c         <= '0;
                        k         <= '0;
                        sol_count <= '0;
                        busy      <= 1'b1;
                    end
                end
                CHECK: begin
                    if (k == r) begin
                        cols[r] <= W_DEFAULT'(c);
                        if (r != LAST) begin
                            r <= r + 1'b1;
                            c <= '0;
                            k <= '0;
                        end
                    end else if (!conflict) begin
                        k <= k + 1'b1;
                    end
                end
                NEXT: begin
                    if (c != LAST) begin
                        c <= c + 1'b1;
                        k <= '0;
                    end
                end
                // Resume the parent row from the column it held.
                BACKTRACK: begin
                    if (r != '0) begin
                        r <= r_m1;
                        c <= cols[r_m1][W-1:0];
                    end
                end
                EMIT:    if (bus.sol_ready) sol_count <= sol_count + 1'b1;
                FINISH:  busy <= 1'b0;
                default: ;
            endcase
        end
    end

    // cols is frozen in EMIT, so the board is stable across any stall.
    assign bus.busy      = busy;
    assign bus.sol_valid = (state == EMIT);
    assign bus.done      = (state == FINISH);
    assign bus.sol_count = sol_count;
    assign bus.sol_board = (state == EMIT) ? packed_all[N*W-1:0] : '0;

endmodule

// File: tb/tb_queen_solver.sv
// Directed bench for queen_solver at N=4, 6 and 8 plus the standalone conflict checker.
module tb_queen_solver;
    import queen_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    queen_solver_if #(.N(4), .W(2)) i4 ();
    queen_solver_if #(.N(6), .W(3)) i6 ();
    queen_solver_if #(.N(8), .W(3)) i8 ();

    queen_solver #(.N(4), .W(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(i4));
    queen_solver #(.N(6), .W(3)) dut6 (.clk(clk), .rst_n(rst_n), .bus(i6));
    queen_solver #(.N(8), .W(3)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8));

    logic [2:0] cr1, cc1, cr2, cc2;
    logic       cconf;
    queen_conflict #(.W(3)) u_conf (
        .r1(cr1), .c1(cc1), .r2(cr2), .c2(cc2), .conflict(cconf)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  q4[$];
    logic [17:0] q6[$];
    logic [23:0] q8[$];
    int done4 = 0, done6 = 0, done8 = 0;

    // Record every accepted solution and every done pulse.
    always @(posedge clk) begin
        if (i4.sol_valid && i4.sol_ready) q4.push_back(i4.sol_board);
        if (i6.sol_valid && i6.sol_ready) q6.push_back(i6.sol_board);
        if (i8.sol_valid && i8.sol_ready) q8.push_back(i8.sol_board);
        if (i4.done) done4++;
        if (i6.done) done6++;
        if (i8.done) done8++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] mk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    function automatic logic [7:0] mk4(input int a0, a1, a2, a3);
        return {2'(a3), 2'(a2), 2'(a1), 2'(a0)};
    endfunction

    initial begin
        logic [23:0] b0;
        logic        ok, stable;
        int          d0, qb;

        rst_n = 1'b0;
        i4.start = 1'b0; i6.start = 1'b0; i8.start = 1'b0;
        i4.sol_ready = 1'b1; i6.sol_ready = 1'b1; i8.sol_ready = 1'b0;
        {cr1, cc1, cr2, cc2} = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(i8.busy), 0);
        check("rst_valid", 32'(i8.sol_valid), 0);
        check("rst_done",  32'(i8.done), 0);
        check("rst_board", 32'(i8.sol_board), 0);
        check("rst_count", 32'(i8.sol_count), 0);
        check("rst_state", 32'(dut8.state), 32'(IDLE));
        rst_n = 1'b1;

        // conflict checker, including the distance-7 aliasing case
        {cr1, cc1, cr2, cc2} = {3'd0, 3'd0, 3'd7, 3'd7}; #1 check("conf_diag7", 32'(cconf), 1);
        {cr1, cc1, cr2, cc2} = {3'd0, 3'd0, 3'd7, 3'd1}; #1 check("conf_alias", 32'(cconf), 0);
        {cr1, cc1, cr2, cc2} = {3'd2, 3'd3, 3'd5, 3'd6}; #1 check("conf_diag3", 32'(cconf), 1);
        {cr1, cc1, cr2, cc2} = {3'd1, 3'd3, 3'd0, 3'd5}; #1 check("conf_clear", 32'(cconf), 0);
        {cr1, cc1, cr2, cc2} = {3'd5, 3'd2, 3'd1, 3'd2}; #1 check("conf_col",   32'(cconf), 1);

        // N=4 full run
        @(negedge clk); i4.start = 1'b1;
        @(negedge clk); i4.start = 1'b0;
        check("n4_busy", 32'(i4.busy), 1);
        d0 = done4;
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin @(negedge clk); ok = i4.done; end
        check("n4_done_seen", 32'(ok), 1);
        check("n4_count", 32'(i4.sol_count), 2);
        @(negedge clk);
        check("n4_busy_off", 32'(i4.busy), 0);
        check("n4_count_hold", 32'(i4.sol_count), 2);
        check("n4_nsol", q4.size(), 2);
        check("n4_sol0", 32'(q4[0]), 32'(mk4(1, 3, 0, 2)));
        check("n4_sol1", 32'(q4[1]), 32'(mk4(2, 0, 3, 1)));
        repeat (5) @(negedge clk);
        check("n4_one_done", done4 - d0, 1);

        // N=6 full run
        i6.start = 1'b1;
        @(negedge clk); i6.start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin @(negedge clk); ok = i6.done; end
        check("n6_done_seen", 32'(ok), 1);
        check("n6_count", 32'(i6.sol_count), 4);
        check("n6_nsol", q6.size(), 4);

        // N=8 full run: stall at the first solution, then a stray start while busy
        i8.start = 1'b1;
        @(negedge clk); i8.start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin @(negedge clk); ok = i8.sol_valid; end
        check("n8_first_valid", 32'(ok), 1);
        b0 = i8.sol_board;
        check("n8_first", 32'(b0), 32'(mk8(0, 4, 7, 5, 2, 6, 1, 3)));
        check("n8_count_stall", 32'(i8.sol_count), 0);
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!(i8.sol_valid === 1'b1 && i8.sol_board === b0 && i8.sol_count === 8'd0)) stable = 1'b0;
        end
        check("n8_stall_hold", 32'(stable), 1);
        i8.sol_ready = 1'b1;
        @(negedge clk);
        check("n8_count_release", 32'(i8.sol_count), 1);
        check("n8_valid_drop", 32'(i8.sol_valid), 0);
        i8.start = 1'b1;
        @(negedge clk); i8.start = 1'b0;
        d0 = done8;
        ok = 1'b0;
        for (int i = 0; i < 90000 && !ok; i++) begin @(negedge clk); ok = i8.done; end
        check("n8_done_seen", 32'(ok), 1);
        check("n8_count", 32'(i8.sol_count), 92);
        @(negedge clk);
        check("n8_busy_off", 32'(i8.busy), 0);
        check("n8_nsol", q8.size(), 92);
        check("n8_sol0", 32'(q8[0]), 32'(mk8(0, 4, 7, 5, 2, 6, 1, 3)));
        check("n8_sol1", 32'(q8[1]), 32'(mk8(0, 5, 7, 2, 6, 3, 1, 4)));
        check("n8_last", 32'(q8[91]), 32'(mk8(7, 3, 0, 2, 5, 1, 6, 4)));
        check("n8_one_done", done8 - d0, 1);

        // reset mid-search after the third solution
        qb = q8.size();
        d0 = done8;
        i8.start = 1'b1;
        @(negedge clk); i8.start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin @(negedge clk); ok = (q8.size() - qb >= 3); end
        check("rs_three_sols", 32'(ok), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rs_busy",  32'(i8.busy), 0);
        check("rs_valid", 32'(i8.sol_valid), 0);
        check("rs_done",  32'(i8.done), 0);
        check("rs_board", 32'(i8.sol_board), 0);
        check("rs_count", 32'(i8.sol_count), 0);
        check("rs_state", 32'(dut8.state), 32'(IDLE));
        rst_n = 1'b1;
        stable = 1'b1;
        repeat (2000) begin
            @(negedge clk);
            if (i8.sol_valid !== 1'b0 || i8.done !== 1'b0 || i8.busy !== 1'b0) stable = 1'b0;
        end
        check("rs_quiet", 32'(stable), 1);
        check("rs_no_done", done8 - d0, 0);

        qb = q8.size();
        i8.start = 1'b1;
        @(negedge clk); i8.start = 1'b0;
        check("rs_restart_busy", 32'(i8.busy), 1);
        check("rs_restart_count", 32'(i8.sol_count), 0);
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin @(negedge clk); ok = (q8.size() > qb); end
        check("rs_restart_sol", 32'(ok), 1);
        check("rs_restart_count1", 32'(i8.sol_count), 1);
        check("rs_restart_first", 32'(q8[qb]), 32'(mk8(0, 4, 7, 5, 2, 6, 1, 3)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
